inst_fetch_responder: RTL and testbench

- Instruction-side memory responder for the pipeline core's fetch port; it serves the other end of the core's rom_ce/rom_addr/rom_data interface.
- Converts each 32-bit word fetch into four sequential byte reads of a byte-wide synchronous RAM and assembles them little-endian.
- Returns the word with a one-cycle valid pulse and holds stall high while a fetch is busy.
- A one-entry last-word buffer serves repeated fetches of the same word in one cycle.

---
 rtl/inst_fetch_responder.sv | 127 ++++++++++++
 tb/tb_inst_fetch_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_responder.sv
//------------------------------------------------------------------------------
// Module  : inst_fetch_responder
// Brief   : Word fetch responder; assembles four byte-RAM reads little-endian.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_fetch_responder #(
   parameter int ADDR_W = 17,
   parameter bit BUF_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rom_ce_i,
   input  logic [31:0]       rom_addr_i,
   input  logic              flush_i,
   input  logic              inv_i,
   output logic [31:0]       rom_data_o,
   output logic              rom_valid_o,
   output logic              stall_o,
   output logic [ADDR_W-1:0] mem_a_o,
   output logic              mem_rd_o,
   input  logic [7:0]        mem_din_i
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RD   = 2'd1;
   localparam logic [1:0] c_WAIT = 2'd2;
   localparam logic [1:0] c_DONE = 2'd3;

   logic [1:0]  r_state;
   logic [1:0]  r_k;
   logic [29:0] r_req_addr;
   logic [29:0] r_tag;
   logic [31:0] r_buf_data;
   logic        r_buf_valid;
   logic [31:0] r_asm;
   logic [31:0] r_rom_data;

   logic        w_accept;
   logic        w_hit;
   logic [31:0] w_word;
   logic        w_unused_addr_lsb;

   assign w_accept = (r_state == c_IDLE) && rom_ce_i && !flush_i;
   assign w_hit    = BUF_EN && r_buf_valid && !inv_i && (rom_addr_i[31:2] == r_tag);
   assign w_word   = {mem_din_i, r_asm[23:0]};
   assign w_unused_addr_lsb = ^rom_addr_i[1:0];

   assign rom_data_o  = r_rom_data;
   assign rom_valid_o = (r_state == c_DONE);
   assign mem_rd_o    = (r_state == c_RD);
   // Byte index never carries into the word address, so reads wrap within the word.
   assign mem_a_o     = (r_state == c_RD) ? {r_req_addr[ADDR_W-3:0], r_k} : '0;
   assign stall_o     = w_accept || (r_state == c_RD) || (r_state == c_WAIT);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= c_IDLE;
         r_k         <= 2'd0;
         r_req_addr  <= '0;
         r_tag       <= '0;
         r_buf_data  <= '0;
         r_buf_valid <= 1'b0;
         r_asm       <= '0;
         r_rom_data  <= '0;
      end else begin
         if (inv_i) begin
            r_buf_valid <= 1'b0;
         end
         case (r_state)
            c_IDLE: begin
               if (w_accept) begin
                  if (w_hit) begin
                     r_rom_data <= r_buf_data;
                     r_state    <= c_DONE;
                  end else begin
                     r_req_addr <= rom_addr_i[31:2];
                     r_k        <= 2'd0;
                     r_state    <= c_RD;
                  end
               end
            end
            c_RD: begin
               if (flush_i) begin
                  r_state <= c_IDLE;
               end else begin
                  // RAM data lags the address by one cycle: lane k-1 arrives now.
                  case (r_k)
                     2'd1:    r_asm[7:0]   <= mem_din_i;
                     2'd2:    r_asm[15:8]  <= mem_din_i;
                     2'd3:    r_asm[23:16] <= mem_din_i;
                     default: ;
                  endcase
                  r_k <= r_k + 2'd1;
                  if (r_k == 2'd3) begin
                     r_state <= c_WAIT;
                  end
               end
            end
            c_WAIT: begin
               if (flush_i) begin
                  r_state <= c_IDLE;
               end else begin
                  r_asm[31:24] <= mem_din_i;
                  r_rom_data   <= w_word;
                  if (BUF_EN) begin
                     r_buf_data  <= w_word;
                     r_tag       <= r_req_addr;
                     r_buf_valid <= !inv_i;
                  end
                  r_state <= c_DONE;
               end
            end
            c_DONE: begin
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_responder.sv
//------------------------------------------------------------------------------
// Module  : tb_inst_fetch_responder
// Brief   : Self-checking bench with a transaction-level fetch/buffer model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch_responder;

   localparam int ADDR_W = 17;
   localparam bit BUF_EN = 1'b1;

   logic              clk = 1'b0;
   logic              rst;
   logic              rom_ce;
   logic [31:0]       rom_addr;
   logic              flush;
   logic              inv;
   logic [31:0]       rom_data;
   logic              rom_valid;
   logic              stall;
   logic [ADDR_W-1:0] mem_a;
   logic              mem_rd;
   logic [7:0]        mem_din = 8'h00;

   logic [7:0] ram [0:(1<<ADDR_W)-1];

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state: one-entry buffer and last delivered word
   bit          m_valid;
   logic [29:0] m_tag;
   logic [31:0] m_data;
   logic [31:0] m_last;

   inst_fetch_responder #(.ADDR_W(ADDR_W), .BUF_EN(BUF_EN)) dut (
      .clk         (clk),
      .rst         (rst),
      .rom_ce_i    (rom_ce),
      .rom_addr_i  (rom_addr),
      .flush_i     (flush),
      .inv_i       (inv),
      .rom_data_o  (rom_data),
      .rom_valid_o (rom_valid),
      .stall_o     (stall),
      .mem_a_o     (mem_a),
      .mem_rd_o    (mem_rd),
      .mem_din_i   (mem_din)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd) mem_din <= ram[mem_a];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] a);
      logic [ADDR_W-1:0] b;
      b = {a[ADDR_W-1:2], 2'b00};
      return {ram[b + 3], ram[b + 2], ram[b + 1], ram[b]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One fetch; flush_c / inv_c name the cycle (0 = request seen) in which
   // that input is raised, or -1 for never.
   task automatic fetch(input logic [31:0] a, input int flush_c, input int inv_c);
      bit          hit, aborted, exp_rd, exp_valid, exp_stall;
      int          last;
      logic [31:0] w;
      w       = word_of(a);
      hit     = BUF_EN && m_valid && (inv_c != 0) && (m_tag == a[31:2]);
      aborted = !hit && flush_c >= 1 && flush_c <= 5;
      last    = hit ? 1 : (aborted ? flush_c : 6);
      for (int c = 0; c <= last; c++) begin
         rom_ce   = 1'b1;
         rom_addr = a;
         flush    = (c == flush_c);
         inv      = (c == inv_c);
         #1;
         exp_rd    = !hit && c >= 1 && c <= 4;
         exp_valid = !aborted && c == last;
         exp_stall = (c == 0) ? 1'b1 : (!hit && c <= 5);
         chk("mem_rd", 32'(mem_rd), 32'(exp_rd));
         if (exp_rd) chk("mem_a", 32'(mem_a), 32'({a[ADDR_W-1:2], 2'(c - 1)}));
         chk("rom_valid", 32'(rom_valid), 32'(exp_valid));
         chk("stall", 32'(stall), 32'(exp_stall));
         chk("rom_data", rom_data, exp_valid ? w : m_last);
         if (exp_valid) m_last = w;
         if (!hit && !aborted && c == 5) begin
            m_tag   = a[31:2];
            m_data  = w;
            m_valid = BUF_EN && (inv_c != 5);
         end else if (c == inv_c) begin
            m_valid = 1'b0;
         end
         step();
      end
      rom_ce = 1'b0;
      flush  = 1'b0;
      inv    = 1'b0;
      #1;
      chk("idle_stall", 32'(stall), 32'd0);
      chk("idle_valid", 32'(rom_valid), 32'd0);
      chk("idle_mem_rd", 32'(mem_rd), 32'd0);
      chk("idle_data", rom_data, m_last);
      step();
   endtask

   task automatic inv_pulse();
      inv = 1'b1;
      #1;
      chk("inv_stall", 32'(stall), 32'd0);
      step();
      inv     = 1'b0;
      m_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_data"},  rom_data, 32'd0);
      chk({tag, "_valid"}, 32'(rom_valid), 32'd0);
      chk({tag, "_stall"}, 32'(stall), 32'd0);
      chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
      chk({tag, "_mem_a"}, 32'(mem_a), 32'd0);
   endtask

   task automatic reset_mid_fetch(input logic [31:0] a);
      rom_ce   = 1'b1;
      rom_addr = a;
      #1;
      chk("rmf_stall0", 32'(stall), 32'd1);
      step();
      chk("rmf_rd1", 32'(mem_rd), 32'd1);
      step();
      rst = 1'b0;
      step();
      rst    = 1'b1;
      rom_ce = 1'b0;
      #1;
      check_reset_outputs("rmf");
      m_valid = 1'b0;
      m_last  = 32'd0;
      step();
   endtask

   initial begin
      logic [31:0] pool [6];
      logic [31:0] a;
      int          fc, ic;
      pool[0] = 32'h0000_0100;
      pool[1] = 32'h0000_0104;
      pool[2] = 32'h0000_0102;
      pool[3] = 32'h0002_0100;
      pool[4] = 32'hFFFF_FFFC;
      pool[5] = 32'h0000_0200;

      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'($urandom);
      ram[17'h100] = 8'h13;
      ram[17'h101] = 8'h05;
      ram[17'h102] = 8'h10;
      ram[17'h103] = 8'h00;

      m_valid  = 1'b0;
      m_tag    = '0;
      m_data   = '0;
      m_last   = '0;
      rst      = 1'b0;
      rom_ce   = 1'b0;
      rom_addr = '0;
      flush    = 1'b0;
      inv      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b1;

      fetch(32'h100, -1, -1);
      chk("first_word", m_last, 32'h0010_0513);
      fetch(32'h102, -1, -1);
      fetch(32'h200, 3, -1);
      fetch(32'h100, -1, -1);
      inv_pulse();
      fetch(32'h100, -1, -1);
      fetch(32'h100, -1, 5);
      fetch(32'h100, -1, -1);
      fetch(32'h100, 1, -1);
      fetch(32'h104, 6, 6);
      reset_mid_fetch(32'h300);
      fetch(32'h100, -1, -1);

      for (int t = 0; t < 80; t++) begin
         a  = pool[$urandom_range(0, 5)];
         fc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1;
         ic = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
         fetch(a, fc, ic);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
